// File: rtl/line_mem_if.sv
// line_mem_if: cache miss handler to backing memory link.
// Carries whole-line refill/write-back requests and ack pulses.
interface line_mem_if #(
  parameter int WORD_SIZE = 16
);
  logic                     req_mem_read;
  logic [WORD_SIZE-1:0]     req_mem_read_address;
  logic                     req_mem_write;
  logic [WORD_SIZE-1:0]     req_mem_write_address;
  logic [4*WORD_SIZE-1:0]   mem_fetch_output;
  logic [4*WORD_SIZE-1:0]   mem_fetch_input;
  logic                     read_ack;
  logic                     write_ack;
  logic                     busy;

  modport master (
    output req_mem_read,
    output req_mem_read_address,
    output req_mem_write,
    output req_mem_write_address,
    output mem_fetch_output,
    input  mem_fetch_input,
    input  read_ack,
    input  write_ack,
    input  busy
  );

  modport slave (
    input  req_mem_read,
    input  req_mem_read_address,
    input  req_mem_write,
    input  req_mem_write_address,
    input  mem_fetch_output,
    output mem_fetch_input,
    output read_ack,
    output write_ack,
    output busy
  );
endinterface

// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: line-organised backing memory behind the data cache.
// Fixed-latency refill and write-back with single-cycle ack pulses.
module line_mem_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int LINE_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  line_mem_if.slave    bus
);

  localparam int         DEPTH  = 1 << LINE_BITS;
  localparam int         LW     = 4 * WORD_SIZE;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_DONE,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic                   r_rd_pend;
  logic [LINE_BITS-1:0]   r_rd_idx;
  logic [LINE_BITS-1:0]   r_wr_idx;
  logic [LW-1:0]          r_wr_data;
  logic [LW-1:0]          r_rd_data;
  logic [LW-1:0]          r_mem [DEPTH];

  logic                   w_lat_wr;
  logic                   w_lat_rd;
  logic                   w_commit;
  logic                   w_load;
  logic                   w_cnt_end;
  logic [LINE_BITS-1:0]   w_rd_idx_in;
  logic [LINE_BITS-1:0]   w_wr_idx_in;
  logic                   w_unused_addr;

  // Upper address bits alias and the low two pick a word inside the line.
  assign w_rd_idx_in   = bus.req_mem_read_address[LINE_BITS+1:2];
  assign w_wr_idx_in   = bus.req_mem_write_address[LINE_BITS+1:2];
  assign w_unused_addr = ^{bus.req_mem_read_address,
                           bus.req_mem_write_address};

  assign w_cnt_end     = (r_cnt == LAT_M1);

  assign bus.read_ack        = (r_state == RD_DONE);
  assign bus.write_ack       = (r_state == WR_DONE);
  assign bus.busy            = (r_state != IDLE);
  assign bus.mem_fetch_input = r_rd_data;

  // Next-state and datapath strobes; write-back always ahead of refill.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat_wr    = 1'b0;
    w_lat_rd    = 1'b0;
    w_commit    = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_mem_write) begin
          w_lat_wr    = 1'b1;
          w_lat_rd    = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = WR_WAIT;
        end else if (bus.req_mem_read) begin
          w_lat_rd    = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (w_cnt_end) begin
          w_commit    = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = WR_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      WR_DONE: begin
        if (r_rd_pend) begin
          // The ack cycle already counts toward the refill wait.
          w_cnt_nxt   = 4'd1;
          w_state_nxt = RD_WAIT;
        end else begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (w_cnt_end) begin
          w_load      = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = RD_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      RD_DONE: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counter, request latches and the registered refill line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= '0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_lat_wr) begin
        r_wr_idx  <= w_wr_idx_in;
        r_wr_data <= bus.mem_fetch_output;
      end
      if (w_lat_rd) begin
        r_rd_idx  <= w_rd_idx_in;
        r_rd_pend <= bus.req_mem_write & bus.req_mem_read;
      end
      if (w_load) begin
        r_rd_data <= r_mem[r_rd_idx];
      end
    end
  end

  // Array write; reset blocks the commit but never clears contents.
  always_ff @(posedge clk) begin
    if (reset_n && w_commit) begin
      r_mem[r_wr_idx] <= r_wr_data;
    end
  end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb_line_mem_ctrl: randomized bench for line_mem_ctrl.
// Reference keeps a plain line array and ack timing from latency rules.
module tb_line_mem_ctrl;

  localparam int LAT = 4;

  logic clk;
  logic reset_n;

  line_mem_if #(.WORD_SIZE(16)) bus();

  line_mem_ctrl #(
    .WORD_SIZE(16),
    .LINE_BITS(8),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  logic [63:0] mdl [256];
  bit          vld [256];
  int          vq[$];
  logic [63:0] prev_rd;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lidx(input logic [15:0] a);
    return (int'(a) / 4) % 256;
  endfunction

  function automatic logic [15:0] pick_ra();
    int i;
    i = vq[$urandom_range(0, vq.size() - 1)];
    return 16'(($urandom & 32'hFC03) | (i * 4));
  endfunction

  task automatic drive(input bit wr, input bit rd, input logic [15:0] wa,
                       input logic [15:0] ra, input logic [63:0] wd);
    bus.req_mem_write         = wr;
    bus.req_mem_read          = rd;
    bus.req_mem_write_address = wa;
    bus.req_mem_read_address  = ra;
    bus.mem_fetch_output      = wd;
  endtask

  task automatic run_txn(input bit wr, input bit rd,
                         input logic [15:0] wa, input logic [15:0] ra,
                         input logic [63:0] wd, input bit noise);
    int f_wr, f_rd, n_wr, n_rd, n_both, last;
    logic [63:0] got_rd;
    logic [63:0] exp_rd;
    f_wr = -1; f_rd = -1;
    n_wr = 0; n_rd = 0; n_both = 0;
    got_rd = '0;
    @(negedge clk);
    drive(wr, rd, wa, ra, wd);
    @(posedge clk);
    if (wr) begin
      mdl[lidx(wa)] = wd;
      if (!vld[lidx(wa)]) begin
        vld[lidx(wa)] = 1'b1;
        vq.push_back(lidx(wa));
      end
    end
    exp_rd = mdl[lidx(ra)];
    last = (wr && rd) ? 2 * LAT : LAT;
    for (int k = 0; k <= 2 * LAT + 3; k++) begin
      @(negedge clk);
      if (k == 0) chk("busy_accept", 64'(bus.busy), 64'd1);
      if (bus.write_ack) begin
        n_wr++;
        if (f_wr < 0) f_wr = k;
      end
      if (bus.read_ack) begin
        n_rd++;
        if (f_rd < 0) begin
          f_rd = k;
          got_rd = bus.mem_fetch_input;
        end
      end
      if (bus.write_ack && bus.read_ack) n_both++;
      if (noise && k < last)
        drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              {$urandom, $urandom});
      else
        drive(1'b0, 1'b0, 16'h0, 16'h0, 64'h0);
    end
    if (wr) begin
      chk("wack_cycle", 64'(f_wr), 64'(LAT));
      chk("wack_count", 64'(n_wr), 64'd1);
    end else begin
      chk("wack_none", 64'(n_wr), 64'd0);
    end
    if (rd) begin
      chk("rack_cycle", 64'(f_rd), 64'(last));
      chk("rack_count", 64'(n_rd), 64'd1);
      chk("rd_data", got_rd, exp_rd);
      prev_rd = exp_rd;
    end else begin
      chk("rack_none", 64'(n_rd), 64'd0);
    end
    chk("ack_overlap", 64'(n_both), 64'd0);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("data_hold", bus.mem_fetch_input, prev_rd);
  endtask

  initial begin
    int kind;
    int n_ack;
    logic [15:0] wa, ra;
    logic [63:0] wd;
    n_chk = 0;
    n_err = 0;
    prev_rd = '0;
    for (int i = 0; i < 256; i++) begin
      mdl[i] = '0;
      vld[i] = 1'b0;
    end
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 64'h0);
    repeat (3) @(negedge clk);
    chk("rst_read_ack", 64'(bus.read_ack), 64'd0);
    chk("rst_write_ack", 64'(bus.write_ack), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_data", bus.mem_fetch_input, 64'd0);
    reset_n = 1'b1;

    // preload line 5, then read it through a non-aligned word address
    run_txn(1'b1, 1'b0, 16'h0014, 16'h0, 64'h1111_2222_3333_4444, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0, 16'h0016, 64'h0, 1'b0);
    // write then separate read of the same line
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0, 16'h0023, 64'h0, 1'b0);
    // simultaneous write-back and refill of the same line
    run_txn(1'b1, 1'b1, 16'h0040, 16'h0040, 64'h0123_4567_89AB_CDEF, 1'b0);
    // high address bits alias
    run_txn(1'b0, 1'b1, 16'h0, 16'h0417, 64'h0, 1'b0);
    // requests toggled while busy are ignored
    run_txn(1'b0, 1'b1, 16'h0, 16'h0021, 64'h0, 1'b1);
    run_txn(1'b1, 1'b0, 16'h0044, 16'h0, 64'h5555_6666_7777_8888, 1'b1);

    // abort a write-back with reset mid-access
    run_txn(1'b1, 1'b0, 16'h0060, 16'h0, 64'h0, 1'b0);
    n_ack = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0060, 16'h0, 64'hDEAD_BEEF_CAFE_F00D);
    @(posedge clk);
    @(negedge clk);
    if (bus.write_ack) n_ack++;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 64'h0);
    @(negedge clk);
    if (bus.write_ack) n_ack++;
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_read_ack", 64'(bus.read_ack), 64'd0);
    chk("abort_write_ack", 64'(bus.write_ack), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_data", bus.mem_fetch_input, 64'd0);
    reset_n = 1'b1;
    prev_rd = '0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (bus.write_ack || bus.read_ack) n_ack++;
    end
    chk("abort_no_ack", 64'(n_ack), 64'd0);
    run_txn(1'b0, 1'b1, 16'h0, 16'h0060, 64'h0, 1'b0);

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      wa = 16'($urandom);
      wd = {$urandom, $urandom};
      if (kind == 2 && $urandom_range(0, 1) == 1)
        ra = 16'(($urandom & 32'hFC03) | (lidx(wa) * 4));
      else
        ra = pick_ra();
      run_txn(kind != 1, kind != 0, wa, ra, wd, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
